hilo_mult_unit: RTL and testbench

- Parametrised, multi-cycle multiply/accumulate unit that owns the architectural HI/LO register pair.
- Sits beside the ALU in EX. It accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO/MUL on a start strobe, computes the product iteratively (one multiplier bit per cycle), and updates HI/LO or the MUL result register.
- Busy/Done handshake lets the hazard unit stall dependent MFHI/MFLO/MUL consumers.

---
 rtl/hilo_mult_unit.sv | 169 ++++++++++++++++
 tb/tb_hilo_mult_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - multi-cycle multiply/accumulate unit owning the HI/LO register pair
//
// Optional feature macro: HILO_FAST_MULT_EN (single-cycle combinational product, RUN bypassed).
//
// Ports:
//   Clk, Rst_n     rising-edge clock, asynchronous active-low reset
//   Start, Op      launch strobe (sampled when not Busy) and opcode
//                  (0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MTHI, 7 MTLO, 8 MUL)
//   A, B           rs / rt operands; A is also the MTHI/MTLO source
//   Busy, Done     operation in flight / one-cycle result-visible pulse
//   HI_out, LO_out architectural HI and LO registers
//   MulOut         low half of the last MUL product
module hilo_mult_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out,
    output logic [WIDTH-1:0] MulOut
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mul_q, mul_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               op_mult;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] product;

`ifndef HILO_FAST_MULT_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     step_sum;
`endif

    assign op_signed = (Op == 4'd0) || (Op == 4'd2) || (Op == 4'd4) || (Op == 4'd8);
    assign op_mult   = (Op <= 4'd5) || (Op == 4'd8);

    // Magnitudes: the most-negative value negates to itself, which read as
    // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    assign a_mag = (op_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag = (op_signed && B[WIDTH-1]) ? -B : B;

    assign product = neg_q ? -prod_q : prod_q;

`ifndef HILO_FAST_MULT_EN
    // Classic shift-add: the upper half accumulates the multiplicand while the
    // multiplier, parked in the lower half, is consumed LSB-first as it shifts out.
    assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_d   = mul_q;
        done_d  = 1'b0;
`ifndef HILO_FAST_MULT_EN
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (op_mult) begin
                        op_d  = Op;
                        neg_d = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef HILO_FAST_MULT_EN
                        prod_d  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                        state_d = S_WRITE;
`else
                        mcand_d = a_mag;
                        prod_d  = {{WIDTH{1'b0}}, b_mag};
                        cnt_d   = '0;
                        state_d = S_RUN;
`endif
                    end else if (Op == 4'd6) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (Op == 4'd7) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end
                end
            end
`ifndef HILO_FAST_MULT_EN
            S_RUN: begin
                prod_d = {step_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end
            end
`endif
            S_WRITE: begin
                case (op_q)
                    4'd0, 4'd1: {hi_d, lo_d} = product;
                    4'd2, 4'd3: {hi_d, lo_d} = {hi_q, lo_q} + product;
                    4'd4, 4'd5: {hi_d, lo_d} = {hi_q, lo_q} - product;
                    4'd8:       mul_d = product[WIDTH-1:0];
                    default:    ;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_q   <= '0;
            done_q  <= 1'b0;
`ifndef HILO_FAST_MULT_EN
            mcand_q <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_q   <= mul_d;
            done_q  <= done_d;
`ifndef HILO_FAST_MULT_EN
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;
    assign HI_out = hi_q;
    assign LO_out = lo_q;
    assign MulOut = mul_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - directed self-checking bench for hilo_mult_unit
module tb_hilo_mult_unit;

    localparam int WIDTH = 32;
`ifdef HILO_FAST_MULT_EN
    localparam int DONE_EDGE = 1;
`else
    localparam int DONE_EDGE = WIDTH + 1;
`endif

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             Start = 1'b0;
    logic [3:0]       Op = 4'd0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI_out;
    logic [WIDTH-1:0] LO_out;
    logic [WIDTH-1:0] MulOut;

    int n_cmp = 0;
    int n_err = 0;

    hilo_mult_unit #(.WIDTH(WIDTH)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .HI_out (HI_out),
        .LO_out (LO_out),
        .MulOut (MulOut)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a Start for one sampling edge; returns 1 time unit after that edge.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Counts edges after the sampling edge until Done, bounded at 100.
    task automatic wait_done(output int edges, output int busy_hi);
        edges   = 0;
        busy_hi = Busy ? 1 : 0;
        while (edges < 100) begin
            @(posedge Clk);
            #1;
            edges++;
            if (Done) break;
            if (Busy) busy_hi++;
        end
    endtask

    initial begin
        int edges;
        int busy_hi;
        int dones;
        int first_done;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_hi",   64'(HI_out), 64'h0);
        chk("rst_lo",   64'(LO_out), 64'h0);
        chk("rst_mul",  64'(MulOut), 64'h0);
        chk("rst_busy", 64'(Busy),   64'h0);
        chk("rst_done", 64'(Done),   64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // MULT -3 * 7 = -21
        issue(4'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("mult_busy_e0", 64'(Busy), 64'h1);
        wait_done(edges, busy_hi);
        chk("mult_latency", 64'(edges),   64'(DONE_EDGE));
        chk("mult_busy_cy", 64'(busy_hi), 64'(DONE_EDGE));
        chk("mult_busy_dn", 64'(Busy),    64'h0);
        chk("mult_hi",      64'(HI_out),  64'hFFFF_FFFF);
        chk("mult_lo",      64'(LO_out),  64'hFFFF_FFEB);

        // MULTU max * max = FFFFFFFE_00000001
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges, busy_hi);
        chk("multu_lat", 64'(edges),  64'(DONE_EDGE));
        chk("multu_hi",  64'(HI_out), 64'hFFFF_FFFE);
        chk("multu_lo",  64'(LO_out), 64'h0000_0001);

        // MULT most-negative squared = 2^62
        issue(4'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges, busy_hi);
        chk("mult_mn_hi", 64'(HI_out), 64'h4000_0000);
        chk("mult_mn_lo", 64'(LO_out), 64'h0000_0000);

        // MTLO: immediate, Done next cycle, never busy
        issue(4'd7, 32'hFFFF_FFFF, 32'h0);
        chk("mtlo_done", 64'(Done),   64'h1);
        chk("mtlo_busy", 64'(Busy),   64'h0);
        chk("mtlo_lo",   64'(LO_out), 64'hFFFF_FFFF);
        chk("mtlo_hi",   64'(HI_out), 64'h4000_0000);

        // MADDU 1*1 onto 40000000_FFFFFFFF carries into HI
        issue(4'd3, 32'h1, 32'h1);
        wait_done(edges, busy_hi);
        chk("maddu_hi", 64'(HI_out), 64'h4000_0001);
        chk("maddu_lo", 64'(LO_out), 64'h0000_0000);

        // MSUB 1*2 from 40000001_00000000 borrows from HI
        issue(4'd4, 32'h1, 32'h2);
        wait_done(edges, busy_hi);
        chk("msub_hi", 64'(HI_out), 64'h4000_0000);
        chk("msub_lo", 64'(LO_out), 64'hFFFF_FFFE);

        // MADD -1*1 onto 0_00000000 via MTHI/MTLO, result wraps negative
        issue(4'd6, 32'h0, 32'h0);
        issue(4'd7, 32'h0, 32'h0);
        issue(4'd2, 32'hFFFF_FFFF, 32'h1);
        wait_done(edges, busy_hi);
        chk("madd_hi", 64'(HI_out), 64'hFFFF_FFFF);
        chk("madd_lo", 64'(LO_out), 64'hFFFF_FFFF);

        // MTHI then MUL 5*6; a second Start mid-operation must be ignored
        issue(4'd6, 32'h1234_5678, 32'h0);
        chk("mthi_hi", 64'(HI_out), 64'h1234_5678);
        issue(4'd8, 32'h5, 32'h6);
        dones      = 0;
        first_done = 0;
        for (int i = 1; i <= 60; i++) begin
`ifndef HILO_FAST_MULT_EN
            if (i == 10) begin
                Start = 1'b1;
                Op    = 4'd6;
                A     = 32'hDEAD_BEEF;
            end
`endif
            @(posedge Clk);
            #1;
            Start = 1'b0;
            if (Done) begin
                dones++;
                if (first_done == 0) first_done = i;
            end
        end
        chk("mul_dones",  64'(dones),      64'h1);
        chk("mul_lat",    64'(first_done), 64'(DONE_EDGE));
        chk("mul_out",    64'(MulOut),     64'h0000_001E);
        chk("mul_hi_keep",64'(HI_out),     64'h1234_5678);
        chk("mul_lo_keep",64'(LO_out),     64'hFFFF_FFFF);

        // Asynchronous reset in the middle of a MULT
        issue(4'd0, 32'h7, 32'h9);
        repeat (14) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("arst_hi",   64'(HI_out), 64'h0);
        chk("arst_lo",   64'(LO_out), 64'h0);
        chk("arst_mul",  64'(MulOut), 64'h0);
        chk("arst_busy", 64'(Busy),   64'h0);
        chk("arst_done", 64'(Done),   64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (Done) dones++;
        end
        chk("arst_nodone", 64'(dones), 64'h0);
        chk("arst_idle",   64'(Busy),  64'h0);

        // Fresh MULT after reset
        issue(4'd0, 32'h2, 32'h3);
        wait_done(edges, busy_hi);
        chk("post_rst_lat", 64'(edges),  64'(DONE_EDGE));
        chk("post_rst_lo",  64'(LO_out), 64'h6);
        chk("post_rst_hi",  64'(HI_out), 64'h0);

        // Undefined opcode: no Done, no busy, registers untouched
        issue(4'd9, 32'hAAAA_AAAA, 32'h5555_5555);
        dones = Done ? 1 : 0;
        busy_hi = Busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (Done) dones++;
            if (Busy) busy_hi++;
        end
        chk("nop_nodone", 64'(dones),   64'h0);
        chk("nop_nobusy", 64'(busy_hi), 64'h0);
        chk("nop_lo",     64'(LO_out),  64'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
